// File: rtl/output_classifier_pkg.sv
// ---------------------------------------------------------------------------
// output_classifier_pkg
// Shared definitions for the output classifier: default widths and neuron
// count, plus the controller state enumeration.
// Ports: none (package).
// ---------------------------------------------------------------------------
package output_classifier_pkg;

    localparam int DEF_N_NEURONS = 10;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IDX_W     = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/output_classifier_relu.sv
// ---------------------------------------------------------------------------
// relu_unit
// Combinational rectifier on the neuron-result input path. Negative
// two's-complement results become zero; non-negative results pass unchanged.
// Ports:
//   din   in   DATA_W  signed neuron result
//   dout  out  DATA_W  rectified (non-negative) result
// ---------------------------------------------------------------------------
module relu_unit
    import output_classifier_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] din,
    output logic        [DATA_W-1:0] dout
);

    function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = x[DATA_W-1] ? '0 : x;
        return r;
    endfunction

    assign dout = relu(din);

endmodule

// File: rtl/output_classifier.sv
// ---------------------------------------------------------------------------
// output_classifier
// Collects N_NEURONS neuron results from the upstream neuron calculator,
// rectifies each one, then scans the stored results one slot per cycle with
// a single unsigned comparator to find the winning class (largest value,
// ties to the lowest index). The result is held until downstream accepts it.
// Ports:
//   clk        in   1                  clock, rising edge
//   reset      in   1                  asynchronous active-low reset
//   clear      in   1                  synchronous abort back to COLLECT
//   in_valid   in   1                  in_data carries a neuron result
//   in_data    in   DATA_W             signed neuron result
//   in_ready   out  1                  result accepted this cycle
//   layer_out  out  N_NEURONS*DATA_W   rectified results, neuron k at [DATA_W*k +: DATA_W]
//   out_valid  out  1                  class_out / max_value valid
//   out_ready  in   1                  downstream consumes the result
//   class_out  out  IDX_W              index of the largest rectified result
//   max_value  out  DATA_W             value of the largest rectified result
// ---------------------------------------------------------------------------
module output_classifier
    import output_classifier_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [N_NEURONS*DATA_W-1:0]   layer_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              class_out,
    output logic [DATA_W-1:0]             max_value
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t              state;
    state_t              state_next;

    logic [DATA_W-1:0]   slots [N_NEURONS];
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    scan_idx;
    logic                fetching;

    logic                vld_p0;
    logic                last_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic [DATA_W-1:0]   cand_p0;

    logic [DATA_W-1:0]   run_max;
    logic [IDX_W-1:0]    run_idx;

    logic [DATA_W-1:0]   relu_data;
    logic                transfer;
    logic                wr_last;
    logic                scan_last;
    logic                cand_wins;
    logic                final_stage;
    logic [DATA_W-1:0]   best_max;
    logic [IDX_W-1:0]    best_idx;

    relu_unit #(
        .DATA_W (DATA_W)
    ) u_relu (
        .din  (in_data),
        .dout (relu_data)
    );

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_layer
        assign layer_out[k*DATA_W +: DATA_W] = slots[k];
    end

    always_comb begin
        in_ready    = (state == COLLECT) && !clear;
        transfer    = in_valid && in_ready;
        wr_last     = (wr_idx == LAST_IDX);
        scan_last   = (scan_idx == LAST_IDX);
        final_stage = vld_p0 && last_p0;

        // Rectified values are never negative, so one unsigned compare is
        // enough. Slot 0 seeds the running max, strictly-greater replaces it.
        cand_wins = (cand_p0 > run_max);
        if ((idx_p0 == '0) || cand_wins) begin
            best_max = cand_p0;
            best_idx = idx_p0;
        end else begin
            best_max = run_max;
            best_idx = run_idx;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (transfer && wr_last)      state_next = SCAN;
                SCAN:    if (final_stage)              state_next = DONE;
                DONE:    if (out_valid && out_ready)   state_next = COLLECT;
                default:                               state_next = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx    <= '0;
            scan_idx  <= '0;
            fetching  <= 1'b0;
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
            idx_p0    <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            class_out <= '0;
            max_value <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                slots[k] <= '0;
            end
        end else if (clear) begin
            wr_idx    <= '0;
            scan_idx  <= '0;
            fetching  <= 1'b0;
            vld_p0    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (transfer) begin
                slots[wr_idx] <= relu_data;
                if (wr_last) begin
                    wr_idx   <= '0;
                    scan_idx <= '0;
                    fetching <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            // Stage p0: fetch one slot per cycle into the compare register.
            vld_p0  <= fetching;
            idx_p0  <= scan_idx;
            last_p0 <= scan_last;
            if (fetching) begin
                if (scan_last) begin
                    scan_idx <= '0;
                    fetching <= 1'b0;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end

            // Stage p1: fold the fetched slot into the running max; the last
            // slot's result goes straight to the output registers.
            if (vld_p0) begin
                run_max <= best_max;
                run_idx <= best_idx;
            end

            if (final_stage) begin
                class_out <= best_idx;
                max_value <= best_max;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fetching) begin
            cand_p0 <= slots[scan_idx];
        end
    end

endmodule
